spi_reg_sequencer: RTL and testbench

Register-access front end for `spi_master`. It turns single read/write register requests (address, length, write data) into an 8-bit AXI-stream byte sequence on `mosi_stream`, and consumes the matching `miso_stream` bytes to build the read response. It sits directly upstream of `spi_master`: it drives that block's `mosi_stream` sink and is the consumer of its `miso_stream` source.

---
 rtl/spi_reg_sequencer_if.sv | 19 +
 rtl/spi_reg_sequencer.sv | 132 +++++++++++++
 tb/tb_spi_reg_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_reg_sequencer_if.sv
// axis_interface: AXI-stream byte bundle shared by spi_reg_sequencer and spi_master.
interface axis_interface #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [ID_WIDTH-1:0] tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  modport Source (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
  modport Sink (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer: turns single register requests into a header+data byte stream for spi_master
// and assembles the returned MISO bytes into the read response.
module spi_reg_sequencer #(
  parameter int ADDR_WIDTH = 7,
  parameter int MAX_BYTES = 4,
  parameter int DATA_WIDTH = 8 * MAX_BYTES,
  parameter int LEN_WIDTH = $clog2(MAX_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  axis_interface.Source         mosi_stream,
  axis_interface.Sink           miso_stream
);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BYTES);
  state_e state_q, state_d;
  logic write_q, write_d, err_q, err_d;
  logic tx_done_q, tx_done_d, rx_done_q, rx_done_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [7:0] tdata_q, tdata_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [DATA_WIDTH-1:0] wsh_q, wsh_d, rdata_q, rdata_d;
  logic legal, accept, tx_hs, tx_last, rx_hs, rx_last, unused_miso;
  assign legal = req_len != '0 && req_len <= MAX_LEN;
  assign accept = state_q == IDLE && req_valid;
  assign tx_hs = tvalid_q && mosi_stream.tready;
  assign tx_last = tx_hs && tx_idx_q == len_q;
  assign rx_hs = state_q == XFER && miso_stream.tvalid && !rx_done_q;
  assign rx_last = rx_hs && rx_idx_q == len_q;
  assign unused_miso = ^{miso_stream.tlast, miso_stream.tkeep, miso_stream.tid, miso_stream.tdest, miso_stream.tuser};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      err_q <= 1'b0;
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tdata_q <= '0;
      len_q <= '0;
      tx_idx_q <= '0;
      rx_idx_q <= '0;
      wsh_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      err_q <= err_d;
      tx_done_q <= tx_done_d;
      rx_done_q <= rx_done_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      tdata_q <= tdata_d;
      len_q <= len_d;
      tx_idx_q <= tx_idx_d;
      rx_idx_q <= rx_idx_d;
      wsh_q <= wsh_d;
      rdata_q <= rdata_d;
    end
  // TX and RX finish independently; the transfer ends once both sides have seen len+1 bytes.
  always_comb
    state_d = accept ? (legal ? XFER : RESP) :
              (state_q == XFER && (tx_done_q || tx_last) && (rx_done_q || rx_last)) ? RESP :
              (state_q == RESP && rsp_ready) ? IDLE : state_q;
  always_comb begin
    write_d = write_q;
    err_d = err_q;
    len_d = len_q;
    tx_done_d = tx_done_q;
    rx_done_d = rx_done_q;
    tvalid_d = tvalid_q;
    tlast_d = tlast_q;
    tdata_d = tdata_q;
    tx_idx_d = tx_idx_q;
    rx_idx_d = rx_idx_q;
    wsh_d = wsh_q;
    rdata_d = rdata_q;
    if (accept) begin
      write_d = req_write;
      len_d = req_len;
      err_d = !legal;
      rdata_d = '0;
      tx_idx_d = '0;
      rx_idx_d = '0;
      tx_done_d = 1'b0;
      rx_done_d = 1'b0;
      tvalid_d = legal;
      tlast_d = 1'b0;
      tdata_d = legal ? {~req_write, req_addr[6:0]} : 8'h00;
      // Left-justify the used bytes so each data beat is simply the top byte of the shifter.
      wsh_d = (req_write && legal) ? req_wdata << (8 * (MAX_BYTES - int'(req_len))) : '0;
    end
    if (tx_hs) begin
      tx_idx_d = tx_idx_q + 1'b1;
      tdata_d = tx_last ? 8'h00 : wsh_q[DATA_WIDTH-1 -: 8];
      wsh_d = wsh_q << 8;
      tlast_d = !tx_last && LEN_WIDTH'(tx_idx_q + 1'b1) == len_q;
      tvalid_d = !tx_last;
      tx_done_d = tx_last;
    end
    if (rx_hs) begin
      rx_idx_d = rx_idx_q + 1'b1;
      rx_done_d = rx_last;
      rdata_d = (rx_idx_q != '0 && !write_q) ? {rdata_q[DATA_WIDTH-9:0], miso_stream.tdata} : rdata_q;
    end
  end
  always_comb begin
    req_ready = reset_n && state_q == IDLE;
    rsp_valid = state_q == RESP;
    rsp_rdata = rdata_q;
    rsp_error = err_q;
    mosi_stream.tvalid = tvalid_q;
    mosi_stream.tdata = tdata_q;
    mosi_stream.tlast = tlast_q;
    mosi_stream.tkeep = '1;
    mosi_stream.tid = '0;
    mosi_stream.tdest = '0;
    mosi_stream.tuser = '0;
    miso_stream.tready = reset_n;
  end
endmodule

// File: tb/tb_spi_reg_sequencer.sv
// tb_spi_reg_sequencer: directed request vectors for spi_reg_sequencer with a cycle-level MISO model
// (late, same-cycle or loopback byte return) and hand sequences for reset and response stall.
module tb_spi_reg_sequencer;
  typedef struct {
    string name;
    logic wr;
    logic [6:0] addr;
    logic [2:0] len;
    logic [31:0] wdata;
    logic [0:4][7:0] miso;
    logic [0:4][7:0] mosi;
    int beats;
    logic [31:0] rdata;
    logic err;
    int stall;
    int hold;
    bit early;
    bit loop;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [6:0] req_addr = '0;
  logic [2:0] req_len = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  int n_chk = 0, n_err = 0;
  string cur = "reset";
  vec_t vecs[$];
  axis_interface mosi ();
  axis_interface miso ();
  spi_reg_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mosi_stream(mosi), .miso_stream(miso)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %h, expected %h", cur, tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(string nm, logic wr, logic [6:0] a, logic [2:0] len, logic [31:0] wd,
                              logic [39:0] mi, logic [39:0] mo, int nb, logic [31:0] rd, logic err,
                              int stall, int hold, bit early, bit loop);
    vec_t v;
    v.name = nm; v.wr = wr; v.addr = a; v.len = len; v.wdata = wd;
    v.miso = mi; v.mosi = mo; v.beats = nb; v.rdata = rd; v.err = err;
    v.stall = stall; v.hold = hold; v.early = early; v.loop = loop;
    return v;
  endfunction
  task automatic run(input vec_t v);
    int nb = 0, it = 0, last_hs = -10, stall = v.stall;
    bit pend = 1'b0, hs, rdy;
    logic [7:0] pbyte = 8'h00;
    cur = v.name;
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_len = v.len; req_wdata = v.wdata;
    step();
    req_valid = 1'b0; req_wdata = '0; req_addr = '0;
    chk("hdr_latency", 32'(mosi.tvalid), 32'(!v.err));
    while (!rsp_valid && it < 200) begin
      rdy = !(nb == 1 && stall > 0);
      if (!rdy) begin
        stall--;
        chk("bp_hold", 32'({mosi.tvalid, mosi.tlast, mosi.tdata}), 32'({1'b1, 1'b0, v.mosi[1]}));
      end
      mosi.tready = rdy;
      hs = mosi.tvalid && rdy;
      miso.tvalid = v.early ? hs : pend;
      miso.tdata = v.early ? (nb < 5 ? v.miso[nb] : 8'h00) : pbyte;
      if (hs) begin
        if (nb < v.beats) begin
          chk($sformatf("beat%0d", nb), 32'({mosi.tlast, mosi.tdata}), 32'({nb == v.beats - 1, v.mosi[nb]}));
          chk("sideband", 32'({mosi.tkeep, mosi.tid, mosi.tdest, mosi.tuser}), 32'h8);
        end else chk("extra_beat", nb, v.beats);
        pbyte = v.loop ? mosi.tdata : (nb < 5 ? v.miso[nb] : 8'h00);
        nb++;
        last_hs = it;
      end
      pend = hs;
      step();
      it++;
    end
    miso.tvalid = 1'b0;
    mosi.tready = 1'b1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("beat_count", nb, v.beats);
    chk("rsp_gap", v.err ? it : it - last_hs, v.err ? 0 : (v.early ? 1 : 2));
    chk("rsp_error", 32'(rsp_error), 32'(v.err));
    chk("rsp_rdata", rsp_rdata, v.rdata);
    chk("tvalid_resp", 32'(mosi.tvalid), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      miso.tvalid = 1'b1;
      miso.tdata = 8'hEE;
      step();
      chk("rsp_stall", 32'({rsp_valid, req_ready}), 32'b10);
      chk("rsp_stall_data", rsp_rdata, v.rdata);
    end
    miso.tvalid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("ret_idle", 32'({req_ready, rsp_valid}), 32'b10);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    mosi.tready = 1'b1;
    miso.tvalid = 1'b0; miso.tdata = '0; miso.tlast = 1'b0;
    miso.tkeep = 1'b1; miso.tid = '0; miso.tdest = '0; miso.tuser = '0;
    vecs.push_back(mk("wr_len2", 1, 7'h05, 2, 32'h0000ABCD, 40'h7777777777, 40'h05ABCD0000, 3, 32'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd_len3", 0, 7'h12, 3, 32'h0, 40'hFF11223300, 40'h9200000000, 4, 32'h00112233, 0, 0, 0, 0, 0));
    vecs.push_back(mk("len0", 1, 7'h05, 0, 32'hFFFFFFFF, 40'h0, 40'h0, 0, 32'h0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("wr_bp", 1, 7'h05, 4, 32'hDEADBEEF, 40'h0102030405, 40'h05DEADBEEF, 5, 32'h0, 0, 5, 0, 0, 0));
    vecs.push_back(mk("rd_hold", 0, 7'h7F, 4, 32'h0, 40'h00A1B2C3D4, 40'hFF00000000, 5, 32'hA1B2C3D4, 0, 0, 10, 0, 0));
    vecs.push_back(mk("len5", 0, 7'h12, 5, 32'h0, 40'h0, 40'h0, 0, 32'h0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("rd_len1", 0, 7'h00, 1, 32'hFFFFFFFF, 40'h553C000000, 40'h8000000000, 2, 32'h0000003C, 0, 0, 0, 0, 0));
    vecs.push_back(mk("wr_len1", 1, 7'h40, 1, 32'h12345678, 40'h9999999999, 40'h4078000000, 2, 32'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd_early", 0, 7'h01, 2, 32'h0, 40'h005AA50000, 40'h8100000000, 3, 32'h00005AA5, 0, 0, 0, 1, 0));
    vecs.push_back(mk("rd_len2", 0, 7'h33, 2, 32'h0, 40'hAA9ABC0000, 40'hB300000000, 3, 32'h00009ABC, 0, 0, 0, 0, 0));
    vecs.push_back(mk("len7", 1, 7'h05, 7, 32'h0000FFFF, 40'h0, 40'h0, 0, 32'h0, 1, 0, 0, 0, 0));
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_error}), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_mosi", 32'({mosi.tvalid, mosi.tlast, mosi.tdata}), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_miso_tready", 32'(miso.tready), 32'd1);
    foreach (vecs[i]) run(vecs[i]);
    cur = "reset_mid";
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h10; req_len = 3'd4;
    step();
    req_valid = 1'b0;
    mosi.tready = 1'b1;
    step();
    step();
    chk("pre_reset_tvalid", 32'({mosi.tvalid, mosi.tdata}), 32'h100);
    #1 reset_n = 1'b0;
    #1;
    chk("async_tvalid", 32'({mosi.tvalid, mosi.tlast, mosi.tdata}), 32'h0);
    chk("async_req_ready", 32'({req_ready, rsp_valid}), 32'b00);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("post_reset_idle", 32'({req_ready, rsp_valid, mosi.tvalid}), 32'b100);
    chk("post_reset_rdata", rsp_rdata, 32'h0);
    run(mk("loop_rd", 0, 7'h2A, 1, 32'h0, 40'h0, 40'hAA00000000, 2, 32'h0, 0, 0, 0, 0, 1));
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
